// File: rtl/count_to_signals.sv
// Thermometer ramp generator: fills signals LSB-first up to min(in_count,4), holds, then pulses done.
// The first one appears the cycle after acceptance; done follows target+HOLD_CYCLES+1 cycles after accept.
module count_to_signals #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_count,
   input  logic       abort,
   output logic [3:0] signals,
   output logic [2:0] level,
   output logic       busy,
   output logic       done,
   output logic [2:0] clamped
);

   typedef enum logic [1:0] {IDLE, RAMP, HOLD, DONE} state_t;

   localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

   state_t     state_q;
   logic [3:0] signals_q;
   logic [2:0] level_q;
   logic [2:0] target_q;
   logic [3:0] hold_q;
   logic       done_q;
   logic       clamped_q;
   logic [2:0] target_d;

   assign target_d = (in_count > 3'd4) ? 3'd4 : in_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         signals_q <= 4'b0000;
         level_q   <= 3'd0;
         target_q  <= 3'd0;
         hold_q    <= 4'd0;
         done_q    <= 1'b0;
         clamped_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // abort has no meaning here; an accept in the same cycle proceeds normally
               if (in_valid) begin
                  target_q  <= target_d;
                  clamped_q <= (in_count > 3'd4);
                  hold_q    <= 4'd0;
                  if (target_d == 3'd0) begin
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                     signals_q <= 4'b0000;
                     level_q   <= 3'd0;
                  end else begin
                     state_q   <= RAMP;
                     signals_q <= 4'b0001;
                     level_q   <= 3'd1;
                  end
               end
            end
            RAMP: begin
               if (abort) begin
                  state_q   <= IDLE;
                  signals_q <= 4'b0000;
                  level_q   <= 3'd0;
                  hold_q    <= 4'd0;
               end else if (level_q == target_q) begin
                  if (HOLD_CYCLES == 0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= HOLD;
                     hold_q  <= HOLD_LOAD;
                  end
               end else begin
                  signals_q <= {signals_q[2:0], 1'b1};
                  level_q   <= level_q + 3'd1;
               end
            end
            HOLD: begin
               if (abort) begin
                  state_q   <= IDLE;
                  signals_q <= 4'b0000;
                  level_q   <= 3'd0;
                  hold_q    <= 4'd0;
               end else if (hold_q == 4'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  hold_q <= hold_q - 4'd1;
               end
            end
            DONE: begin
               state_q   <= IDLE;
               signals_q <= 4'b0000;
               level_q   <= 3'd0;
               hold_q    <= 4'd0;
            end
            default: begin
               state_q   <= IDLE;
               signals_q <= 4'b0000;
               level_q   <= 3'd0;
               hold_q    <= 4'd0;
            end
         endcase
      end
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = ~in_ready;
   assign signals  = signals_q;
   assign level    = level_q;
   assign done     = done_q;
   assign clamped  = {2'b00, clamped_q};

endmodule
